// File: rtl/mfda_ctrl_pkg.sv
// Shared control definitions for the microfluidic inlet/pump sequencing logic.
// Holds the dose FSM states, the inlet select encoding and the pump phase patterns.
package mfda_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_PUMP   = 2'd2,
      ST_CLOSE  = 2'd3
   } dose_state_e;

   localparam logic [1:0] SEL_RESERVED = 2'd3;

   // One stroke is three phases; 1 = pump valve pressurised/closed.
   localparam logic [2:0] PUMP_PHASE_A = 3'b110;
   localparam logic [2:0] PUMP_PHASE_B = 3'b011;
   localparam logic [2:0] PUMP_PHASE_C = 3'b101;
   localparam logic [2:0] PUMP_IDLE    = 3'b000;
   localparam logic [1:0] PHASE_LAST   = 2'd2;

   function automatic logic [2:0] inlet_onehot(input logic [1:0] sel);
      return 3'b001 << sel;
   endfunction

endpackage

// File: rtl/pump_phase_gen.sv
// Peristaltic pump phase generator: steps 110/011/101 for each stroke while enabled
// and flags the final cycle of the last stroke so the sequencer can leave PUMP.
module pump_phase_gen
   import mfda_ctrl_pkg::*;
#(
   parameter int PHASE_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [7:0] strokes,
   output logic [2:0] pump_valve,
   output logic       last_stroke_done
);

   localparam int TW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(PHASE_CYCLES - 1);

   logic [TW-1:0] timer_q;
   logic [1:0]    phase_q;
   logic [7:0]    strokes_q;
   logic          phase_end;

   assign phase_end = (timer_q == TIMER_LAST);

   // While disabled the stroke counter tracks the latched command so it is primed on entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q   <= '0;
         phase_q   <= '0;
         strokes_q <= '0;
      end else if (!enable) begin
         timer_q   <= '0;
         phase_q   <= '0;
         strokes_q <= strokes;
      end else if (phase_end) begin
         timer_q <= '0;
         if (phase_q == PHASE_LAST) begin
            phase_q   <= '0;
            strokes_q <= strokes_q - 8'd1;
         end else begin
            phase_q <= phase_q + 2'd1;
         end
      end else begin
         timer_q <= timer_q + TW'(1);
      end
   end

   always_comb begin
      pump_valve = PUMP_IDLE;
      if (enable) begin
         case (phase_q)
            2'd0:    pump_valve = PUMP_PHASE_A;
            2'd1:    pump_valve = PUMP_PHASE_B;
            2'd2:    pump_valve = PUMP_PHASE_C;
            default: pump_valve = PUMP_IDLE;
         endcase
      end
   end

   assign last_stroke_done = enable && phase_end && (phase_q == PHASE_LAST) && (strokes_q == 8'd1);

endmodule

// File: rtl/inlet_dose_sequencer.sv
// Dose sequencer: opens one inlet, settles, runs N pump strokes, closes, settles,
// then pulses done (with err for reserved select or abort).
module inlet_dose_sequencer
   import mfda_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 16,
   parameter int PHASE_CYCLES  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_sel,
   input  logic [7:0] cmd_strokes,
   input  logic       abort,
   output logic [2:0] inlet_valve,
   output logic [2:0] pump_valve,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   dose_state_e   state_q;
   logic [SW-1:0] settle_q;
   logic [7:0]    strokes_q;
   logic [2:0]    inlet_q;
   logic          pump_en_q;
   logic          ready_q;
   logic          busy_q;
   logic          done_q;
   logic          err_q;
   logic          aborted_q;
   logic          last_stroke_done;
   logic [2:0]    pump_pattern;

   pump_phase_gen #(
      .PHASE_CYCLES(PHASE_CYCLES)
   ) u_pump (
      .clk              (clk),
      .rst_n            (rst_n),
      .enable           (pump_en_q),
      .strokes          (strokes_q),
      .pump_valve       (pump_pattern),
      .last_stroke_done (last_stroke_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         settle_q  <= '0;
         strokes_q <= '0;
         inlet_q   <= '0;
         pump_en_q <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // Degenerate commands complete immediately without touching any valve.
               if (cmd_valid && ready_q) begin
                  if (cmd_sel == SEL_RESERVED || cmd_strokes == 8'd0) begin
                     done_q <= 1'b1;
                     err_q  <= (cmd_sel == SEL_RESERVED);
                  end else begin
                     state_q   <= ST_SETTLE;
                     strokes_q <= cmd_strokes;
                     inlet_q   <= inlet_onehot(cmd_sel);
                     settle_q  <= SETTLE_LAST;
                     busy_q    <= 1'b1;
                     ready_q   <= 1'b0;
                     aborted_q <= 1'b0;
                  end
               end
            end
            ST_SETTLE: begin
               if (abort) begin
                  state_q   <= ST_CLOSE;
                  inlet_q   <= '0;
                  settle_q  <= SETTLE_LAST;
                  aborted_q <= 1'b1;
               end else if (settle_q == '0) begin
                  state_q   <= ST_PUMP;
                  pump_en_q <= 1'b1;
               end else begin
                  settle_q <= settle_q - SW'(1);
               end
            end
            ST_PUMP: begin
               if (abort || last_stroke_done) begin
                  state_q   <= ST_CLOSE;
                  inlet_q   <= '0;
                  pump_en_q <= 1'b0;
                  settle_q  <= SETTLE_LAST;
                  aborted_q <= abort;
               end
            end
            ST_CLOSE: begin
               if (settle_q == '0) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
                  err_q   <= aborted_q;
               end else begin
                  settle_q <= settle_q - SW'(1);
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               inlet_q   <= '0;
               pump_en_q <= 1'b0;
               busy_q    <= 1'b0;
               ready_q   <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready   = ready_q;
   assign inlet_valve = inlet_q;
   assign pump_valve  = pump_pattern;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_inlet_dose_sequencer.sv
// Directed bench for inlet_dose_sequencer: per-cycle comparison of all outputs
// against hand-derived dose timelines (S=16, P=8).
module tb_inlet_dose_sequencer;

   localparam int S = 16;
   localparam int P = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_sel = 2'd0;
   logic [7:0] cmd_strokes = 8'd0;
   logic       abort = 1'b0;
   logic [2:0] inlet_valve;
   logic [2:0] pump_valve;
   logic       busy;
   logic       done;
   logic       err;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0] inlet;
      logic [2:0] pump;
      logic       busy;
      logic       done;
      logic       err;
      logic       ready;
   } obs_t;

   localparam obs_t IDLE_OBS = '{inlet: 3'b000, pump: 3'b000, busy: 1'b0, done: 1'b0, err: 1'b0, ready: 1'b1};

   inlet_dose_sequencer #(
      .SETTLE_CYCLES(S),
      .PHASE_CYCLES (P)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_sel     (cmd_sel),
      .cmd_strokes (cmd_strokes),
      .abort       (abort),
      .inlet_valve (inlet_valve),
      .pump_valve  (pump_valve),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   function automatic obs_t observe();
      return '{inlet: inlet_valve, pump: pump_valve, busy: busy, done: done, err: err, ready: cmd_ready};
   endfunction

   // Expected outputs k cycles after the accept edge; abort_k>0 means abort sampled at edge t+abort_k.
   function automatic obs_t expect_dose(input int k, input int sel, input int n, input int abort_k);
      obs_t e;
      int   active_end;
      int   ph;
      e = IDLE_OBS;
      active_end = (abort_k > 0) ? abort_k : S + 3 * n * P;
      if (k <= active_end) begin
         e.inlet = 3'b001 << sel;
         e.busy  = 1'b1;
         e.ready = 1'b0;
         if (k > S) begin
            ph = ((k - S - 1) / P) % 3;
            e.pump = (ph == 0) ? 3'b110 : (ph == 1) ? 3'b011 : 3'b101;
         end
      end else if (k <= active_end + S) begin
         e.busy  = 1'b1;
         e.ready = 1'b0;
      end else if (k == active_end + S + 1) begin
         e.done = 1'b1;
         e.err  = (abort_k > 0);
      end
      return e;
   endfunction

   task automatic start_cmd(input logic [1:0] sel, input logic [7:0] n, input bit hold, input bit abort_too);
      @(negedge clk);
      cmd_valid   = 1'b1;
      cmd_sel     = sel;
      cmd_strokes = n;
      abort       = abort_too;
      @(posedge clk);
      #1;
      abort = 1'b0;
      if (!hold) cmd_valid = 1'b0;
   endtask

   // Follows one accepted dose cycle by cycle; optionally offers the next command from cycle next_k.
   task automatic test_dose(input string name, input int sel, input int n, input int abort_k,
                            input int next_k, input int next_sel, input int next_n);
      obs_t got;
      obs_t exp;
      int   done_k;
      int   last_k;
      done_k = ((abort_k > 0) ? abort_k : S + 3 * n * P) + S + 1;
      last_k = (next_k > 0) ? done_k : done_k + 3;
      for (int k = 1; k <= last_k; k++) begin
         @(negedge clk);
         got = observe();
         exp = expect_dose(k, sel, n, abort_k);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got inlet=%b pump=%b busy=%b done=%b err=%b ready=%b exp inlet=%b pump=%b busy=%b done=%b err=%b ready=%b",
                     name, k, got.inlet, got.pump, got.busy, got.done, got.err, got.ready,
                     exp.inlet, exp.pump, exp.busy, exp.done, exp.err, exp.ready);
         end
         abort = (abort_k > 0 && k == abort_k);
         if (next_k > 0 && k == next_k) begin
            cmd_valid   = 1'b1;
            cmd_sel     = 2'(next_sel);
            cmd_strokes = 8'(next_n);
         end
      end
      if (next_k > 0) begin
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
      end
      $display("dose %s sel=%0d strokes=%0d abort_k=%0d done_k=%0d", name, sel, n, abort_k, done_k);
   endtask

   task automatic test_reset();
      obs_t got;
      cmd_valid = 1'b1;
      cmd_sel   = 2'd1;
      cmd_strokes = 8'd3;
      repeat (3) @(negedge clk);
      got = observe();
      checks++;
      if (got !== IDLE_OBS) begin
         errors++;
         $display("FAIL reset_hold got %b exp %b", got, IDLE_OBS);
      end
      cmd_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      got = observe();
      checks++;
      if (got !== IDLE_OBS) begin
         errors++;
         $display("FAIL reset_release got %b exp %b", got, IDLE_OBS);
      end
      $display("reset checked");
   endtask

   task automatic test_degenerate();
      logic [1:0] sels [3]   = '{2'd0, 2'd3, 2'd3};
      logic [7:0] nums [3]   = '{8'd0, 8'd5, 8'd0};
      logic       errs [3]   = '{1'b0, 1'b1, 1'b1};
      obs_t got;
      obs_t exp;
      for (int i = 0; i < 3; i++) begin
         start_cmd(sels[i], nums[i], 1'b0, 1'b0);
         @(negedge clk);
         got = observe();
         exp = IDLE_OBS;
         exp.done = 1'b1;
         exp.err  = errs[i];
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL degenerate_pulse sel=%0d n=%0d got %b exp %b", sels[i], nums[i], got, exp);
         end
         @(negedge clk);
         got = observe();
         checks++;
         if (got !== IDLE_OBS) begin
            errors++;
            $display("FAIL degenerate_after sel=%0d n=%0d got %b exp %b", sels[i], nums[i], got, IDLE_OBS);
         end
         $display("degenerate sel=%0d strokes=%0d err_exp=%b", sels[i], nums[i], errs[i]);
      end
   endtask

   task automatic test_normal();
      // abort high during the accept edge must be ignored
      start_cmd(2'd1, 8'd2, 1'b0, 1'b1);
      test_dose("normal", 1, 2, 0, 0, 0, 0);
   endtask

   task automatic test_abort();
      start_cmd(2'd2, 8'd4, 1'b0, 1'b0);
      test_dose("abort", 2, 4, 30, 35, 0, 1);
      test_dose("after_abort", 0, 1, 0, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      start_cmd(2'd0, 8'd1, 1'b1, 1'b0);
      test_dose("b2b_first", 0, 1, 0, 1, 2, 2);
      test_dose("b2b_second", 2, 2, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mid();
      obs_t got;
      obs_t exp;
      start_cmd(2'd2, 8'd3, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      got = observe();
      exp = expect_dose(40, 2, 3, 0);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL reset_mid_before got %b exp %b", got, exp);
      end
      #1 rst_n = 1'b0;
      #1;
      got = observe();
      checks++;
      if (got !== IDLE_OBS) begin
         errors++;
         $display("FAIL reset_mid_async got %b exp %b", got, IDLE_OBS);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         got = observe();
         checks++;
         if (got !== IDLE_OBS) begin
            errors++;
            $display("FAIL reset_mid_after k=%0d got %b exp %b", k, got, IDLE_OBS);
         end
      end
      $display("reset mid-dose checked");
      start_cmd(2'd1, 8'd1, 1'b0, 1'b0);
      test_dose("post_reset", 1, 1, 0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_normal();
      test_degenerate();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
